// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
//   Shared definitions for the I2C register-write sequencer: register map of
//   the downstream I2C master core, control/status bit positions, the enable
//   value for CTR, the status code and FSM state enumerations, and a helper
//   that selects the CR command for each byte of a register write.
package i2c_seq_pkg;

  // Core register map (CR and SR share an address: write = CR, read = SR)
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  // Command register bits
  localparam int CR_STA  = 7;
  localparam int CR_STO  = 6;
  localparam int CR_RD   = 5;
  localparam int CR_WR   = 4;
  localparam int CR_ACK  = 3;
  localparam int CR_IACK = 0;

  // Status register bits
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  // Core enabled, interrupt disabled
  localparam logic [7:0] CTR_EN = 8'h80;

  // STOP on its own, used to release the bus after a failed byte
  localparam logic [7:0] CR_ABORT = 8'(1 << CR_STO);

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_ARB     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_INIT_LO,
    ST_INIT_HI,
    ST_INIT_CTR,
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_POLL,
    ST_ABORT_CR,
    ST_ABORT_POLL,
    ST_FINISH
  } state_e;

  // CR command for byte k of a write: address byte opens with START, the
  // data byte closes with STOP, the register byte is a plain write.
  function automatic logic [7:0] byte_cr_cmd(input logic [1:0] k);
    logic [7:0] v;
    v        = '0;
    v[CR_WR] = 1'b1;
    if (k == 2'd0) v[CR_STA] = 1'b1;
    if (k == 2'd2) v[CR_STO] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_single_access.sv
// wb_single_access
//   Performs one Wishbone classic access at a time towards the I2C core.
//   The sequencer raises 'start' with adr/dat/we; this block launches the
//   strobe, holds the bus fields stable until the acknowledge, then pulses
//   'done' for one cycle with the read data captured on the ack cycle.
//
//   Ports
//     clk, srst        clock, synchronous active-high reset
//     start            request an access (sampled only while idle)
//     adr, dat, we     access fields, latched when the access starts
//     done             one-cycle pulse after the acknowledged cycle
//     rdata            data captured from wb_dat_r on the ack cycle
//     wb_adr, wb_dat_w, wb_we, wb_stb   bus outputs (registered)
//     wb_dat_r, wb_ack                  bus inputs
module wb_single_access
  import i2c_seq_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic [2:0] adr,
  input  logic [7:0] dat,
  input  logic       we,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] wb_adr,
  output logic [7:0] wb_dat_w,
  output logic       wb_we,
  output logic       wb_stb,
  input  logic [7:0] wb_dat_r,
  input  logic       wb_ack
);

  logic       stb_reg;
  logic [2:0] adr_reg;
  logic [7:0] dat_reg;
  logic       we_reg;
  logic       done_reg;
  logic [7:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      stb_reg   <= 1'b0;
      adr_reg   <= ADR_PRERLO;
      dat_reg   <= '0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (stb_reg) begin
        // Ack only counts while the strobe is up; stb drops on this edge.
        if (wb_ack) begin
          stb_reg   <= 1'b0;
          done_reg  <= 1'b1;
          rdata_reg <= wb_dat_r;
        end
      end else if (start && !done_reg) begin
        // Refusing a start during the done cycle guarantees at least one
        // idle cycle between consecutive strobes.
        stb_reg <= 1'b1;
        adr_reg <= adr;
        dat_reg <= dat;
        we_reg  <= we;
      end
    end
  end

  assign wb_stb   = stb_reg;
  assign wb_adr   = adr_reg;
  assign wb_dat_w = dat_reg;
  assign wb_we    = we_reg;
  assign done     = done_reg;
  assign rdata    = rdata_reg;

endmodule

// File: rtl/i2c_reg_write_seq.sv
// i2c_reg_write_seq
//   Wishbone master that drives the register port of an I2C master core.
//   After reset it programs the prescaler and enables the core, then runs
//   one single-byte register write per accepted command:
//     START + {dev,W}, register address, data + STOP.
//   Each byte is loaded into TXR, launched through CR, and SR is polled
//   until the transfer finishes. Arbitration loss, NACK and poll timeout
//   end the command early; NACK and timeout first release the bus with STOP.
//
//   Parameters
//     PRESCALE     value written to PRERhi:PRERlo
//     POLL_LIMIT   max SR reads per byte (and for the STOP release), >= 1
//
//   Ports
//     wb_clk_i, wb_rst_i                 clock, synchronous active-high reset
//     cmd_valid_i/cmd_ready_o            command handshake
//     cmd_dev_i, cmd_reg_i, cmd_dat_i    device address, register, data
//     busy_o                             init or command in progress
//     done_o, err_o                      end-of-command pulse and its status
//     wb_adr_o .. wb_ack_i               Wishbone master port to the core
module i2c_reg_write_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter int          POLL_LIMIT = 4096
)
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_dev_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_dat_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] err_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  localparam int              PCW      = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0]  POLL_MAX = PCW'(POLL_LIMIT);

  state_e         state_reg, state_next;
  logic [1:0]     k_reg, k_next;
  err_e           err_code_reg, err_code_next;
  err_e           err_o_reg;
  logic [PCW-1:0] poll_cnt_reg, poll_cnt_next, poll_cnt_inc;
  logic           issued_reg;

  logic [6:0]     dev_reg;
  logic [7:0]     regaddr_reg;
  logic [7:0]     data_reg;
  logic [7:0]     txr_byte;

  logic           acc_active;
  logic           acc_start;
  logic [2:0]     acc_adr;
  logic [7:0]     acc_dat;
  logic           acc_we;
  logic           acc_done;
  logic [7:0]     acc_rdata;
  logic           unused_sr_bits;

  wb_single_access u_access (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .start    (acc_start),
    .adr      (acc_adr),
    .dat      (acc_dat),
    .we       (acc_we),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .wb_adr   (wb_adr_o),
    .wb_dat_w (wb_dat_o),
    .wb_we    (wb_we_o),
    .wb_stb   (wb_stb_o),
    .wb_dat_r (wb_dat_i),
    .wb_ack   (wb_ack_i)
  );

  // Only these SR bits drive decisions.
  assign unused_sr_bits = ^{acc_rdata[4:2], acc_rdata[0]};

  // Each access state requests exactly one access; 'issued' remembers that
  // the request is in flight and clears on done so a repeated poll simply
  // re-requests on the following cycle.
  assign acc_start = acc_active && !issued_reg;

  // Saturating increment so a tiny counter never wraps back to zero.
  assign poll_cnt_inc = (poll_cnt_reg == POLL_MAX) ? poll_cnt_reg
                                                   : poll_cnt_reg + PCW'(1);

  always_comb begin
    txr_byte = data_reg;
    case (k_reg)
      2'd0:    txr_byte = {dev_reg, 1'b0};
      2'd1:    txr_byte = regaddr_reg;
      default: txr_byte = data_reg;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_INIT_LO;
      k_reg        <= 2'd0;
      err_code_reg <= ERR_OK;
      err_o_reg    <= ERR_OK;
      poll_cnt_reg <= '0;
      issued_reg   <= 1'b0;
      dev_reg      <= '0;
      regaddr_reg  <= '0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      err_code_reg <= err_code_next;
      poll_cnt_reg <= poll_cnt_next;
      if (acc_done) begin
        issued_reg <= 1'b0;
      end else if (acc_start) begin
        issued_reg <= 1'b1;
      end
      if (state_reg == ST_IDLE && cmd_valid_i) begin
        dev_reg     <= cmd_dev_i;
        regaddr_reg <= cmd_reg_i;
        data_reg    <= cmd_dat_i;
      end
      // The status becomes visible together with done_o and is held after.
      if (state_next == ST_FINISH) begin
        err_o_reg <= err_code_next;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    err_code_next = err_code_reg;
    poll_cnt_next = poll_cnt_reg;
    acc_active    = 1'b0;
    acc_adr       = ADR_SR;
    acc_dat       = '0;
    acc_we        = 1'b0;

    case (state_reg)
      ST_INIT_LO: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_PRERLO;
        acc_dat    = PRESCALE[7:0];
        if (acc_done) state_next = ST_INIT_HI;
      end

      ST_INIT_HI: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_PRERHI;
        acc_dat    = PRESCALE[15:8];
        if (acc_done) state_next = ST_INIT_CTR;
      end

      ST_INIT_CTR: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_CTR;
        acc_dat    = CTR_EN;
        if (acc_done) state_next = ST_IDLE;
      end

      ST_IDLE: begin
        if (cmd_valid_i) begin
          k_next        = 2'd0;
          err_code_next = ERR_OK;
          state_next    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        acc_active    = 1'b1;
        acc_we        = 1'b1;
        acc_adr       = ADR_TXR;
        acc_dat       = txr_byte;
        poll_cnt_next = '0;
        if (acc_done) state_next = ST_ISSUE;
      end

      ST_ISSUE: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_CR;
        acc_dat    = byte_cr_cmd(k_reg);
        if (acc_done) state_next = ST_POLL;
      end

      ST_POLL: begin
        acc_active = 1'b1;
        acc_adr    = ADR_SR;
        if (acc_done) begin
          poll_cnt_next = poll_cnt_inc;
          if (acc_rdata[SR_AL]) begin
            // The core has already let go of the bus: no STOP needed.
            err_code_next = ERR_ARB;
            state_next    = ST_FINISH;
          end else if (acc_rdata[SR_TIP]) begin
            if (poll_cnt_inc == POLL_MAX) begin
              err_code_next = ERR_TIMEOUT;
              state_next    = ST_ABORT_CR;
            end
          end else if (acc_rdata[SR_RXACK]) begin
            err_code_next = ERR_NACK;
            state_next    = ST_ABORT_CR;
          end else if (k_reg == 2'd2) begin
            state_next = ST_FINISH;
          end else begin
            k_next     = k_reg + 2'd1;
            state_next = ST_LOAD;
          end
        end
      end

      ST_ABORT_CR: begin
        acc_active    = 1'b1;
        acc_we        = 1'b1;
        acc_adr       = ADR_CR;
        acc_dat       = CR_ABORT;
        // The STOP release gets its own full poll budget.
        poll_cnt_next = '0;
        if (acc_done) state_next = ST_ABORT_POLL;
      end

      ST_ABORT_POLL: begin
        acc_active = 1'b1;
        acc_adr    = ADR_SR;
        if (acc_done) begin
          poll_cnt_next = poll_cnt_inc;
          if (!acc_rdata[SR_BUSY] || poll_cnt_inc == POLL_MAX) begin
            state_next = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_INIT_LO;
      end
    endcase
  end

  assign cmd_ready_o = (state_reg == ST_IDLE);
  assign busy_o      = (state_reg != ST_IDLE);
  assign done_o      = (state_reg == ST_FINISH);
  assign err_o       = err_o_reg;

endmodule

// File: tb/tb_i2c_reg_write_seq.sv
// tb_i2c_reg_write_seq
//   Directed bench for i2c_reg_write_seq with a behavioural I2C core on the
//   Wishbone port. Expected register writes and status codes are queued when
//   a command is driven and checked as the DUT produces them.
module tb_i2c_reg_write_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_dat = '0;
  logic       busy, done;
  logic [1:0] err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic       wb_we_o, wb_stb_o, wb_ack_i;
  logic       ack_real = 1'b0;
  logic       ack_stray = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // core model controls
  int ack_delay = 0;
  bit stray_en = 1'b0;
  int nack_byte = -1;
  int al_byte = -1;
  bit tip_forever = 1'b0;
  int tip_reads = 1;

  // core model state
  int wait_cnt = 0;
  int cur_byte = 0;
  int tip_left = 0;
  int busy_left = 0;
  int sr_reads = 0;
  int last_poll_reads = 0;
  logic [11:0] cap_fields = '0;

  logic [10:0] exp_q[$];   // {adr, dat} of expected writes, in order
  logic [1:0]  err_q[$];   // expected status per command

  assign wb_ack_i = ack_real | ack_stray;

  always #5 clk = ~clk;

  i2c_reg_write_seq #(.PRESCALE(16'd99), .POLL_LIMIT(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_dev_i   (cmd_dev),
    .cmd_reg_i   (cmd_reg),
    .cmd_dat_i   (cmd_dat),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we_o),
    .wb_stb_o    (wb_stb_o),
    .wb_ack_i    (wb_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural I2C core, evaluated on the falling edge.
  always @(negedge clk) begin : core_model
    logic [7:0] sr;
    ack_stray = 1'b0;
    if (rst) begin
      ack_real  = 1'b0;
      wait_cnt  = 0;
      tip_left  = 0;
      busy_left = 0;
    end else if (ack_real) begin
      ack_real = 1'b0;
    end else if (wb_stb_o) begin
      if (wait_cnt == 0) cap_fields = {wb_we_o, wb_adr_o, wb_dat_o};
      else check("bus_stable_during_stb", {wb_we_o, wb_adr_o, wb_dat_o}, cap_fields);
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        ack_real = 1'b1;
        if (wb_we_o) begin
          $display("[TB] write adr=%0d dat=0x%02h", wb_adr_o, wb_dat_o);
          if (exp_q.size() == 0) begin
            check("write_has_expectation", 32'(exp_q.size()), 32'd1);
          end else begin
            check("write_adr_dat", {wb_adr_o, wb_dat_o}, exp_q.pop_front());
          end
          if (wb_adr_o == 3'd4) begin
            if (wb_dat_o[4]) begin
              cur_byte = wb_dat_o[7] ? 0 : cur_byte + 1;
              tip_left = tip_reads;
            end else if (wb_dat_o[6]) begin
              last_poll_reads = sr_reads;
              busy_left = 1;
              tip_left = 0;
            end
            sr_reads = 0;
          end
        end else begin
          sr = 8'h00;
          if (tip_forever || tip_left > 0) begin
            sr[1] = 1'b1;
            sr[6] = 1'b1;
            if (!tip_forever) tip_left--;
          end else begin
            sr[5] = (cur_byte == al_byte);
            sr[7] = (cur_byte == nack_byte);
            sr[6] = (busy_left > 0);
            if (busy_left > 0) busy_left--;
          end
          wb_dat_i = sr;
          sr_reads++;
        end
      end else begin
        wait_cnt++;
      end
    end else if (stray_en && ($urandom_range(0, 1) == 1)) begin
      // Raised only while stb is low and dropped before stb can be sampled high.
      ack_stray = 1'b1;
    end
  end

  task automatic push_w(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_init();
    push_w(3'd0, 8'h63);
    push_w(3'd1, 8'h00);
    push_w(3'd2, 8'h80);
  endtask

  task automatic push_full(input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] dt);
    push_w(3'd3, {dv, 1'b0}); push_w(3'd4, 8'h90);
    push_w(3'd3, rg);         push_w(3'd4, 8'h10);
    push_w(3'd3, dt);         push_w(3'd4, 8'h50);
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!cmd_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_bound", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic offer_cmd(input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] dt);
    wait_ready(2000);
    cmd_dev = dv; cmd_reg = rg; cmd_dat = dt;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
  endtask

  task automatic run_cmd(input string name, input logic [6:0] dv, input logic [7:0] rg,
                         input logic [7:0] dt, input logic [1:0] exp_err);
    int n = 0;
    logic [1:0] e;
    err_q.push_back(exp_err);
    offer_cmd(dv, rg, dt);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    e = err_q.pop_front();
    check({name, "_err"}, {30'd0, err}, {30'd0, e});
    $display("[TB] %s: dev=0x%02h reg=0x%02h dat=0x%02h err=%0d", name, dv, rg, dt, err);
    @(negedge clk);
    check({name, "_done_one_cycle_ready_back"}, {30'd0, done, cmd_ready}, 32'd1);
    check({name, "_err_held"}, {30'd0, err}, {30'd0, e});
    check({name, "_writes_consumed"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_stb_we_adr_dat", {19'd0, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 32'd0);
    check("rst_ready_done_err", {28'd0, cmd_ready, done, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // Init sequence
    push_init();
    rst = 1'b0;
    wait_ready(200);
    check("init_writes_consumed", 32'(exp_q.size()), 32'd0);
    check("idle_busy_low", {31'd0, busy}, 32'd0);

    // All bytes acknowledged
    push_full(7'h1A, 8'h0F, 8'hA5);
    run_cmd("ack_all", 7'h1A, 8'h0F, 8'hA5, 2'd0);

    // Address byte NACKed: STOP release, no register byte
    nack_byte = 0;
    push_w(3'd3, 8'h34); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40);
    run_cmd("nack_addr", 7'h1A, 8'h0F, 8'hA5, 2'd1);
    nack_byte = -1;

    // Arbitration lost on the register byte: no STOP
    al_byte = 1;
    push_w(3'd3, 8'h34); push_w(3'd4, 8'h90); push_w(3'd3, 8'h0F); push_w(3'd4, 8'h10);
    run_cmd("arb_lost", 7'h1A, 8'h0F, 8'hA5, 2'd2);
    al_byte = -1;

    push_full(7'h50, 8'h01, 8'h3C);
    run_cmd("after_arb", 7'h50, 8'h01, 8'h3C, 2'd0);

    // TIP stuck: exactly POLL_LIMIT reads then STOP release
    tip_forever = 1'b1;
    push_w(3'd3, 8'h34); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40);
    run_cmd("timeout", 7'h1A, 8'h0F, 8'hA5, 2'd3);
    check("timeout_poll_reads", 32'(last_poll_reads), 32'd8);
    tip_forever = 1'b0;

    // Slow acknowledge with stray acks between accesses
    ack_delay = 5;
    stray_en = 1'b1;
    push_full(7'h2D, 8'h80, 8'hFF);
    run_cmd("slow_ack", 7'h2D, 8'h80, 8'hFF, 2'd0);

    // Reset while polling
    tip_forever = 1'b1;
    push_w(3'd3, 8'h34); push_w(3'd4, 8'h90);
    offer_cmd(7'h1A, 8'h0F, 8'hA5);
    n = 0;
    while (!(wb_stb_o && !wb_we_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("poll_stb_seen", {31'd0, wb_stb_o & ~wb_we_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midpoll_stb_low", {31'd0, wb_stb_o}, 32'd0);
    check("rst_midpoll_busy_ready", {30'd0, busy, cmd_ready}, 32'd2);
    check("rst_midpoll_writes_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    tip_forever = 1'b0;
    exp_q.delete();
    push_init();
    rst = 1'b0;
    wait_ready(500);
    check("reinit_writes_consumed", 32'(exp_q.size()), 32'd0);

    // Normal operation after the re-init
    ack_delay = 0;
    stray_en = 1'b0;
    push_full(7'h1A, 8'h0F, 8'hA5);
    run_cmd("post_reset", 7'h1A, 8'h0F, 8'hA5, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
